// File: rtl/stream_distributor.sv
// One-input, NCH-output stream distributor with one-entry output slots per channel.
// Optional broadcast mode (mode 10) is built only when STREAM_DISTRIBUTOR_BROADCAST_EN is defined.
module stream_distributor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      select_line,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     input_data,
  output logic                 in_ready,
  output logic [NCH-1:0]       out_valid,
  output logic [NCH*WIDTH-1:0] out_data,
  input  logic [NCH-1:0]       out_ready
);

  typedef enum logic [1:0] {
    ModeAddr  = 2'b00,
    ModeRr    = 2'b01,
    ModeBcast = 2'b10,
    ModeRsvd  = 2'b11
  } mode_e;

  localparam logic [SELW-1:0] LastCh = SELW'(NCH - 1);

  mode_e                mode_sel;
  logic [SELW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH*WIDTH-1:0] data_q, data_d;
  logic [NCH-1:0]       target;
  logic                 slots_free;
  logic                 xfer;

  assign mode_sel = mode_e'(mode);

  // An out-of-range select matches no channel, so an empty target mask also blocks in_ready.
  always_comb begin
    target = '0;
    unique case (mode_sel)
      ModeAddr: begin
        for (int k = 0; k < NCH; k++) begin
          target[k] = (select_line == SELW'(k));
        end
      end
      ModeRr: begin
        for (int k = 0; k < NCH; k++) begin
          target[k] = (rr_ptr_q == SELW'(k));
        end
      end
`ifdef STREAM_DISTRIBUTOR_BROADCAST_EN
      ModeBcast: target = '1;
`endif
      default: target = '0;
    endcase
  end

  assign slots_free = &(~target | ~valid_q | out_ready);
  assign in_ready   = rst_n & enable & (|target) & slots_free;
  assign xfer       = in_valid & in_ready;

  // A write takes priority over a drain so a same-cycle drain+write keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < NCH; k++) begin
      if (xfer && target[k]) begin
        valid_d[k]                = 1'b1;
        data_d[k*WIDTH +: WIDTH] = input_data;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && (mode_sel == ModeRr)) begin
      rr_ptr_d = (rr_ptr_q == LastCh) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule
